// File: rtl/systolic_array_ctrl_if.sv
// Control bundle between the layer decoder, the tile sequencer and the
// systolic array / ibuf / wbuf / bbuf / obuf request ports.
interface systolic_array_ctrl_if #(
  parameter int unsigned CNT_WIDTH       = 16,
  parameter int unsigned OBUF_ADDR_WIDTH = 16,
  parameter int unsigned BBUF_ADDR_WIDTH = 16
);
  logic                       start;
  logic [CNT_WIDTH-1:0]       cfg_num_rows;
  logic [CNT_WIDTH-1:0]       cfg_num_passes;
  logic [OBUF_ADDR_WIDTH-1:0] cfg_obuf_base;
  logic [BBUF_ADDR_WIDTH-1:0] cfg_bias_base;
  logic                       cfg_bias_en;
  logic                       buf_valid;

  logic                       busy;
  logic                       done;
  logic                       acc_clear;
  logic                       ibuf_read_req;
  logic                       wbuf_read_req;
  logic                       bias_read_req;
  logic [BBUF_ADDR_WIDTH-1:0] bias_read_addr;
  logic                       bias_prev_sw;
  logic                       obuf_read_req;
  logic [OBUF_ADDR_WIDTH-1:0] obuf_read_addr;
  logic                       obuf_write_req;
  logic [OBUF_ADDR_WIDTH-1:0] obuf_write_addr;

  modport master (
    output start, cfg_num_rows, cfg_num_passes, cfg_obuf_base, cfg_bias_base,
           cfg_bias_en, buf_valid,
    input  busy, done, acc_clear, ibuf_read_req, wbuf_read_req, bias_read_req,
           bias_read_addr, bias_prev_sw, obuf_read_req, obuf_read_addr,
           obuf_write_req, obuf_write_addr
  );

  modport slave (
    input  start, cfg_num_rows, cfg_num_passes, cfg_obuf_base, cfg_bias_base,
           cfg_bias_en, buf_valid,
    output busy, done, acc_clear, ibuf_read_req, wbuf_read_req, bias_read_req,
           bias_read_addr, bias_prev_sw, obuf_read_req, obuf_read_addr,
           obuf_write_req, obuf_write_addr
  );
endinterface

// File: rtl/systolic_array_ctrl.sv
// Output-tile sequencer for the systolic array: issues compute beats per row and
// pass, tracks array latency with a delay line and orders obuf read-after-write.
module systolic_array_ctrl #(
  parameter int unsigned ARRAY_N         = 4,
  parameter int unsigned ARRAY_M         = 4,
  parameter int unsigned PIPE_LAT        = ARRAY_N + ARRAY_M + 2,
  parameter int unsigned CNT_WIDTH       = 16,
  parameter int unsigned OBUF_ADDR_WIDTH = 16,
  parameter int unsigned BBUF_ADDR_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  systolic_array_ctrl_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] LAT_C = CNT_WIDTH'(PIPE_LAT);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_GAP, S_DRAIN, S_DONE} state_e;

  state_e                     state_q, state_d;
  logic [CNT_WIDTH-1:0]       rows_q, rows_d, passes_q, passes_d;
  logic [CNT_WIDTH-1:0]       row_q, row_d, pass_q, pass_d;
  logic [OBUF_ADDR_WIDTH-1:0] obase_q, obase_d;
  logic [BBUF_ADDR_WIDTH-1:0] bbase_q, bbase_d;
  logic                       bias_en_q, bias_en_d;
  logic                       busy_q, busy_d, done_q, done_d, acc_clear_q, acc_clear_d;
  logic                       beat_q, beat_d, bias_req_q, bias_req_d, prev_sw_q, prev_sw_d;
  logic                       rd_req_q, rd_req_d;
  logic [BBUF_ADDR_WIDTH-1:0] bias_addr_q, bias_addr_d;
  logic [OBUF_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, waddr_q, waddr_d;
  logic [PIPE_LAT-1:0]        dl_v_q;
  logic [OBUF_ADDR_WIDTH-1:0] dl_a_q [PIPE_LAT];
  logic                       drain_ok_c, last_row_c, last_pass_c;

  // True when every in-flight beat will have reached obuf by the next edge.
  always_comb begin
    drain_ok_c = 1'b1;
    if (PIPE_LAT > 1) drain_ok_c = !beat_q;
    for (int i = 0; i < int'(PIPE_LAT) - 2; i++) begin
      if (dl_v_q[i]) drain_ok_c = 1'b0;
    end
  end

  assign last_row_c  = (row_q == rows_q - CNT_WIDTH'(1));
  assign last_pass_c = (pass_q == passes_q - CNT_WIDTH'(1));

  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    passes_d    = passes_q;
    obase_d     = obase_q;
    bbase_d     = bbase_q;
    bias_en_d   = bias_en_q;
    row_d       = row_q;
    pass_d      = pass_q;
    busy_d      = (state_q != S_IDLE);
    done_d      = 1'b0;
    acc_clear_d = 1'b0;
    beat_d      = 1'b0;
    bias_req_d  = 1'b0;
    bias_addr_d = '0;
    prev_sw_d   = 1'b0;
    rd_req_d    = 1'b0;
    rd_addr_d   = '0;
    waddr_d     = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          busy_d = 1'b1;
          if (bus.cfg_num_rows == '0 || bus.cfg_num_passes == '0) begin
            state_d = S_DONE;
          end else begin
            rows_d    = bus.cfg_num_rows;
            passes_d  = bus.cfg_num_passes;
            obase_d   = bus.cfg_obuf_base;
            bbase_d   = bus.cfg_bias_base;
            bias_en_d = bus.cfg_bias_en;
            row_d     = '0;
            pass_d    = '0;
            state_d   = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        acc_clear_d = 1'b1;
        state_d     = S_RUN;
      end
      S_RUN: begin
        if (bus.buf_valid) begin
          beat_d  = 1'b1;
          waddr_d = obase_q + OBUF_ADDR_WIDTH'(row_q);
          if (pass_q == '0) begin
            bias_req_d  = bias_en_q;
            bias_addr_d = bias_en_q ? bbase_q + BBUF_ADDR_WIDTH'(row_q) : '0;
          end else begin
            prev_sw_d = 1'b1;
            rd_req_d  = 1'b1;
            rd_addr_d = obase_q + OBUF_ADDR_WIDTH'(row_q);
          end
          if (last_row_c) begin
            row_d = '0;
            if (last_pass_c) begin
              state_d = S_DRAIN;
            end else begin
              pass_d = pass_q + CNT_WIDTH'(1);
              // Short passes would read a row before its previous write lands.
              if (rows_q <= LAT_C) state_d = S_GAP;
            end
          end else begin
            row_d = row_q + CNT_WIDTH'(1);
          end
        end
      end
      S_GAP:   if (drain_ok_c) state_d = S_RUN;
      S_DRAIN: if (drain_ok_c) state_d = S_DONE;
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rows_q      <= '0;
      passes_q    <= '0;
      obase_q     <= '0;
      bbase_q     <= '0;
      bias_en_q   <= 1'b0;
      row_q       <= '0;
      pass_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      acc_clear_q <= 1'b0;
      beat_q      <= 1'b0;
      bias_req_q  <= 1'b0;
      bias_addr_q <= '0;
      prev_sw_q   <= 1'b0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      waddr_q     <= '0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      passes_q    <= passes_d;
      obase_q     <= obase_d;
      bbase_q     <= bbase_d;
      bias_en_q   <= bias_en_d;
      row_q       <= row_d;
      pass_q      <= pass_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      acc_clear_q <= acc_clear_d;
      beat_q      <= beat_d;
      bias_req_q  <= bias_req_d;
      bias_addr_q <= bias_addr_d;
      prev_sw_q   <= prev_sw_d;
      rd_req_q    <= rd_req_d;
      rd_addr_q   <= rd_addr_d;
      waddr_q     <= waddr_d;
    end
  end

  // Array latency model; the last stage drives the obuf write port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dl_v_q <= '0;
      for (int i = 0; i < int'(PIPE_LAT); i++) dl_a_q[i] <= '0;
    end else begin
      dl_v_q[0] <= beat_q;
      dl_a_q[0] <= waddr_q;
      for (int i = 1; i < int'(PIPE_LAT); i++) begin
        dl_v_q[i] <= dl_v_q[i-1];
        dl_a_q[i] <= dl_a_q[i-1];
      end
    end
  end

  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.acc_clear       = acc_clear_q;
  assign bus.ibuf_read_req   = beat_q;
  assign bus.wbuf_read_req   = beat_q;
  assign bus.bias_read_req   = bias_req_q;
  assign bus.bias_read_addr  = bias_addr_q;
  assign bus.bias_prev_sw    = prev_sw_q;
  assign bus.obuf_read_req   = rd_req_q;
  assign bus.obuf_read_addr  = rd_addr_q;
  assign bus.obuf_write_req  = dl_v_q[PIPE_LAT-1];
  assign bus.obuf_write_addr = dl_a_q[PIPE_LAT-1];

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Bench for systolic_array_ctrl: builds the expected per-cycle request timeline
// of a tile from its config and the buf_valid pattern, then compares every cycle.
module tb_systolic_array_ctrl;

  localparam int L    = 10;
  localparam int MAXS = 2048;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        acc;
    logic        ibuf;
    logic        wbuf;
    logic        breq;
    logic [15:0] baddr;
    logic        psw;
    logic        rreq;
    logic [15:0] raddr;
    logic        wreq;
    logic [15:0] waddr;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  systolic_array_ctrl_if bus_if ();

  systolic_array_ctrl #(
    .ARRAY_N(4), .ARRAY_M(4), .PIPE_LAT(L),
    .CNT_WIDTH(16), .OBUF_ADDR_WIDTH(16), .BBUF_ADDR_WIDTH(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  int   total = 0;
  int   bad   = 0;
  obs_t exp_v [MAXS];
  bit   bv    [MAXS];

  function automatic obs_t observe();
    obs_t o;
    o.busy  = bus_if.busy;
    o.done  = bus_if.done;
    o.acc   = bus_if.acc_clear;
    o.ibuf  = bus_if.ibuf_read_req;
    o.wbuf  = bus_if.wbuf_read_req;
    o.breq  = bus_if.bias_read_req;
    o.baddr = bus_if.bias_read_addr;
    o.psw   = bus_if.bias_prev_sw;
    o.rreq  = bus_if.obuf_read_req;
    o.raddr = bus_if.obuf_read_addr;
    o.wreq  = bus_if.obuf_write_req;
    o.waddr = bus_if.obuf_write_addr;
    return o;
  endfunction

  // Entered and left on a negedge. Sample s is taken after the s-th edge
  // counted from the edge that accepts start (s=0).
  task automatic run_tile(input string name, input int nr, input int np,
                          input logic [15:0] obase, input logic [15:0] bbase,
                          input logic ben, input int mode);
    int   issue_s, next_ok, last_s, done_s, n_wr;
    obs_t got;
    for (int s = 0; s < MAXS; s++) begin
      exp_v[s] = '0;
      case (mode)
        0:       bv[s] = 1'b1;
        1:       bv[s] = (s % 4 == 0) || (s % 4 == 3);
        default: bv[s] = 1'($urandom_range(0, 1));
      endcase
    end
    done_s = 1;
    if (nr != 0 && np != 0) begin
      exp_v[1].acc = 1'b1;
      next_ok = 2;
      last_s  = 2;
      for (int p = 0; p < np; p++) begin
        for (int r = 0; r < nr; r++) begin
          issue_s = next_ok;
          while (issue_s < MAXS - L - 4 && !bv[issue_s]) issue_s++;
          exp_v[issue_s].ibuf = 1'b1;
          exp_v[issue_s].wbuf = 1'b1;
          if (p == 0) begin
            if (ben) begin
              exp_v[issue_s].breq  = 1'b1;
              exp_v[issue_s].baddr = bbase + 16'(r);
            end
          end else begin
            exp_v[issue_s].psw   = 1'b1;
            exp_v[issue_s].rreq  = 1'b1;
            exp_v[issue_s].raddr = obase + 16'(r);
          end
          exp_v[issue_s + L].wreq  = 1'b1;
          exp_v[issue_s + L].waddr = obase + 16'(r);
          next_ok = issue_s + 1;
          // a pass no longer than the latency waits for its last write
          if (r == nr - 1 && p != np - 1 && nr <= L) next_ok = issue_s + L + 1;
          last_s = issue_s;
        end
      end
      done_s = last_s + L + 1;
    end
    total++;
    if (done_s + 2 >= MAXS) begin
      bad++;
      $display("FAIL %s timeline: got done at %0d want below %0d", name, done_s, MAXS - 2);
      return;
    end
    for (int s = 0; s <= done_s; s++) exp_v[s].busy = 1'b1;
    exp_v[done_s].done = 1'b1;

    bus_if.start          = 1'b1;
    bus_if.cfg_num_rows   = 16'(nr);
    bus_if.cfg_num_passes = 16'(np);
    bus_if.cfg_obuf_base  = obase;
    bus_if.cfg_bias_base  = bbase;
    bus_if.cfg_bias_en    = ben;
    bus_if.buf_valid      = bv[0];
    n_wr = 0;
    for (int s = 0; s <= done_s + 1; s++) begin
      @(posedge clk);
      @(negedge clk);
      got = observe();
      total++;
      if (got !== exp_v[s]) begin
        bad++;
        $display("FAIL %s cycle %0d: got %h want %h", name, s, got, exp_v[s]);
      end
      if (got.wreq === 1'b1) n_wr++;
      // a second start with a different cfg must be ignored
      bus_if.start = (s == 0);
      if (s == 0) begin
        bus_if.cfg_num_rows   = 16'($urandom_range(1, 40));
        bus_if.cfg_num_passes = 16'($urandom_range(1, 4));
        bus_if.cfg_obuf_base  = 16'($urandom);
        bus_if.cfg_bias_base  = 16'($urandom);
        bus_if.cfg_bias_en    = ~ben;
      end
      bus_if.buf_valid = bv[s + 1];
    end
    bus_if.start = 1'b0;
    total++;
    if (n_wr != nr * np) begin
      bad++;
      $display("FAIL %s write_count: got %0d want %0d", name, n_wr, nr * np);
    end
  endtask

  task automatic test_reset();
    obs_t got;
    reset                 = 1'b0;
    bus_if.start          = 1'b0;
    bus_if.cfg_num_rows   = '0;
    bus_if.cfg_num_passes = '0;
    bus_if.cfg_obuf_base  = '0;
    bus_if.cfg_bias_base  = '0;
    bus_if.cfg_bias_en    = 1'b0;
    bus_if.buf_valid      = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    got = observe();
    total++;
    if (got !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", got);
    end
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      got = observe();
      total++;
      if (got !== '0) begin
        bad++;
        $display("FAIL idle_outputs: got %h want 0", got);
      end
    end
  endtask

  task automatic test_bias_single();
    run_tile("bias_3x1", 3, 1, 16'h0010, 16'h0020, 1'b1, 0);
  endtask

  task automatic test_no_gap();
    run_tile("nogap_16x3", 16, 3, 16'h0000, 16'h0040, 1'b0, 0);
    run_tile("rows_eq_lat", L, 2, 16'h0100, 16'h0200, 1'b1, 0);
    run_tile("rows_lat_p1", L + 1, 2, 16'h0300, 16'h0400, 1'b0, 0);
  endtask

  task automatic test_gap();
    run_tile("gap_2x2", 2, 2, 16'h0030, 16'h0000, 1'b1, 0);
    run_tile("gap_1x3", 1, 3, 16'h0050, 16'h0060, 1'b0, 0);
  endtask

  task automatic test_stall();
    run_tile("stall_5x2", 5, 2, 16'h0070, 16'h0080, 1'b1, 1);
    run_tile("stall_12x2", 12, 2, 16'h0090, 16'h00A0, 1'b0, 1);
  endtask

  task automatic test_zero();
    run_tile("zero_rows", 0, 3, 16'h0011, 16'h0022, 1'b1, 0);
    run_tile("zero_passes", 4, 0, 16'h0033, 16'h0044, 1'b1, 0);
  endtask

  task automatic test_addr_wrap();
    run_tile("wrap_obuf", 4, 2, 16'hFFFE, 16'hFFFD, 1'b1, 0);
  endtask

  task automatic test_reset_midrun();
    obs_t got;
    bus_if.start          = 1'b1;
    bus_if.cfg_num_rows   = 16'd8;
    bus_if.cfg_num_passes = 16'd2;
    bus_if.cfg_obuf_base  = 16'h0500;
    bus_if.cfg_bias_base  = 16'h0600;
    bus_if.cfg_bias_en    = 1'b1;
    bus_if.buf_valid      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    got = observe();
    total++;
    if (got.ibuf !== 1'b1 || got.busy !== 1'b1) begin
      bad++;
      $display("FAIL midrun_active: got beat=%b busy=%b want 1 1", got.ibuf, got.busy);
    end
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    got = observe();
    total++;
    if (got !== '0) begin
      bad++;
      $display("FAIL midrun_reset: got %h want 0", got);
    end
    reset = 1'b1;
    for (int i = 0; i < L + 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      got = observe();
      total++;
      if (got !== '0) begin
        bad++;
        $display("FAIL after_reset cycle %0d: got %h want 0", i, got);
      end
    end
    run_tile("after_reset", 6, 2, 16'h0700, 16'h0800, 1'b1, 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      run_tile($sformatf("rand%0d", t), int'($urandom_range(1, 20)),
               int'($urandom_range(1, 3)), 16'($urandom), 16'($urandom),
               1'($urandom_range(0, 1)), 2);
    end
  endtask

  initial begin
    test_reset();
    test_bias_single();
    test_no_gap();
    test_gap();
    test_stall();
    test_zero();
    test_reset_midrun();
    test_addr_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
